bcd_updown_stopwatch: RTL and testbench
=======================================

// Module: bcd_updown_stopwatch
// PURPOSE
//  N-digit BCD up/down counter with a button-driven direction state machine, a power-of-two tick
//  prescaler, saturate/wrap mode and preset load. Drives a multiplexed active-low 7-segment display.
//  Generalises the 4-digit stopwatch: parametrised digit count, BCD counting (no divider chain),
//  wrap mode, preset load and synchronous reset. Top-level counter feeding the board display.
// PARAMETERS
//  DIGITS    4    number of BCD digits counted and displayed (1..8)
//  RATE_W    5    width of rate input; tick period = 2**rate clk cycles
//  SCAN_DIV  100  clk cycles per display digit slot (>= 2*BLANK+1)
//  BLANK     10   blanking cycles at start and at end of each digit slot
// PORTS
//  clk        in   1          single system clock, all logic on rising edge
//  rst        in   1          synchronous active-high reset
//  btn        in   4          async buttons: [3]=clear, [2]=stop, [1]=up, [0]=down (level)
//  rate       in   RATE_W     async tick-rate select
//  wrap_en    in   1          1: wrap at limits, 0: saturate (clk-synchronous)
//  load_en    in   1          1-cycle preset strobe (clk-synchronous)
//  load_val   in   4*DIGITS   BCD preset value, digit 0 in [3:0]
//  count      out  4*DIGITS   current BCD count, digit 0 in [3:0]
//  led        out  3          [2]=at_limit, [1]=dir UP, [0]=dir DOWN
//  seg        out  7          segment pattern, active-low, {g..a}
//  an         out  DIGITS     digit enables, active-low; an[0] = digit 0 (least significant)
// BEHAVIOUR
//  - Reset (rst=1 at an edge): count=0, dir=STOP, prescaler=0, led=0, an=all 1s, seg=7'h7F,
//    scan counter=0, digit index=0. Synchroniser flops clear to 0.
//  - btn and rate pass through 2-flop synchronisers. A level present before edge n takes effect
//    in the state and outputs after edge n+2, i.e. 3 edges of latency. wrap_en and load are unsynchronised.
//  - Direction FSM states: STOP, UP, DOWN. Per cycle, highest priority wins:
//    btn[3] -> count=0, prescaler=0, dir=STOP, load and tick suppressed; btn[2] -> STOP;
//    btn[1] -> UP; btn[0] -> DOWN. Re-asserting the current direction changes nothing.
//  - Prescaler: cleared while dir=STOP. Otherwise it increments each cycle. When prescaler >=
//    (2**rate)-1 a tick fires and the prescaler clears, so the tick period is 2**rate cycles
//    (rate=0: every cycle). The >= compare means lowering rate mid-count never stalls.
//    A direction change does not clear the prescaler.
//  - load_en (no clear pending): count = load_val, with any digit >9 forced to 9. A tick in
//    the same cycle is dropped. The prescaler is unaffected.
//  - Tick uses the dir value updated this cycle. UP: BCD increment with ripple carry
//    (0009->0010, 0999->1000). DOWN: BCD decrement with borrow (0100->0099).
//  - Limits: UP at all-9s gives 0 if wrap_en, else hold. DOWN at 0 gives all-9s if wrap_en, else hold.
//  - led[2] = !wrap_en && ((count==all-9s && dir==UP) || (count==0 && dir==DOWN)), registered.
//    It updates in the same cycle as count and dir.
//  - Display: scan counter runs 0..SCAN_DIV-1 and then wraps. The digit index increments at wrap,
//    from DIGITS-1 back to 0. an = all 1s when scan<BLANK or scan>=SCAN_DIV-BLANK, else
//    ~(1<<digit). seg is registered at scan==BLANK from the current digit value:
//    0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex). seg holds until the next load.
//  - Count changing mid-slot does not alter seg until the next slot. Display runs in all FSM states.
//  - rst mid-operation takes priority over everything, including an in-flight btn or load.
// TESTING
//  1 rst=1 two cycles -> count=0, led=000, an=1111, seg=7F; release, no btn -> count stays 0.
//  2 rate=0, btn[1] held -> led=010 after 3 edges; count 0008,0009,0010 on successive cycles.
//  3 rate=3, load 0099, UP -> first change to 0100 8 cycles after the tick phase starts; then every 8.
//  4 load 9999, wrap_en=0, UP -> holds 9999, led=110. Set wrap_en=1 -> next tick gives 0000, led=010.
//  5 count 0000, DOWN, wrap_en=0 -> led=101, holds. btn[1]+btn[0] together -> UP wins.
//    btn[3]+btn[1] -> STOP, count=0.
//  6 load 1234, DIGITS=4 -> slot0: an=1111 for cycles 0..9, an=1110 with seg=19 for cycles 10..89,
//    an=1111 for 90..99. Slot1: an=1101, seg=30. Slot3 then wraps to slot0.

Source files
------------

// File: rtl/bcd_updown_stopwatch.sv
// BCD up/down stopwatch with a button-driven direction FSM, a power-of-two tick
// prescaler, saturate/wrap limits, preset load and a multiplexed active-low
// 7-segment display driver. The count, LEDs and display outputs are all registered.
module bcd_updown_stopwatch #(
  parameter int DIGITS   = 4,
  parameter int RATE_W   = 5,
  parameter int SCAN_DIV = 100,
  parameter int BLANK    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            btn,
  input  logic [RATE_W-1:0]     rate,
  input  logic                  wrap_en,
  input  logic                  load_en,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [2:0]            led,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  // The prescaler must reach 2**(2**RATE_W - 1) - 1 at the slowest rate.
  localparam int PW = (1 << RATE_W) - 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [4*DIGITS-1:0] ALL9    = {DIGITS{4'h9}};
  localparam logic [SW-1:0]       BLANK_S = SW'(BLANK);
  localparam logic [SW-1:0]       END_S   = SW'(SCAN_DIV - BLANK);
  localparam logic [SW-1:0]       LAST_S  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]       LAST_D  = DW'(DIGITS - 1);
  localparam logic [PW-1:0]       ONE_P   = PW'(1);

  typedef enum logic [1:0] {
    DIR_STOP = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------------
  logic [3:0]        btn_meta_q, btn_sync_q;
  logic [RATE_W-1:0] rate_meta_q, rate_sync_q;

  // Two-flop synchronisers for the asynchronous buttons and rate select.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_q  <= '0;
      btn_sync_q  <= '0;
      rate_meta_q <= '0;
      rate_sync_q <= '0;
    end else begin
      btn_meta_q  <= btn;
      btn_sync_q  <= btn_meta_q;
      rate_meta_q <= rate;
      rate_sync_q <= rate_meta_q;
    end
  end

  logic clear_req;
  assign clear_req = btn_sync_q[3];

  // ---------------------------------------------------------------------------
  // Direction FSM
  // ---------------------------------------------------------------------------
  dir_t dir_q, dir_d;

  // Direction state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= DIR_STOP;
    end else begin
      dir_q <= dir_d;
    end
  end

  // Next direction: clear and stop beat up, up beats down; no button holds.
  always_comb begin
    dir_d = dir_q;
    if (btn_sync_q[3] || btn_sync_q[2]) begin
      dir_d = DIR_STOP;
    end else if (btn_sync_q[1]) begin
      dir_d = DIR_UP;
    end else if (btn_sync_q[0]) begin
      dir_d = DIR_DOWN;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [PW-1:0] presc_thr;
  logic          tick;

  // 2**rate - 1; at the top rate the shift overflows to 0 and the
  // subtraction wraps to all-ones, which is exactly the wanted threshold.
  assign presc_thr = (ONE_P << rate_sync_q) - ONE_P;
  assign tick      = (dir_d != DIR_STOP) && (presc_q >= presc_thr);

  // Prescaler next state: idle while stopped or clearing, restart on tick.
  always_comb begin
    presc_d = presc_q + ONE_P;
    if (clear_req || (dir_d == DIR_STOP) || tick) begin
      presc_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // BCD arithmetic: ripple carry/borrow across digits, saturated preset
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] inc_val, dec_val, load_sat;
  logic [DIGITS:0]     carry, borrow;
  logic                all_nine, all_zero;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur_dig;
      logic [3:0] pre_dig;
      assign cur_dig = count_q[4*gi +: 4];
      assign pre_dig = load_val[4*gi +: 4];

      // A digit moves only when every lower digit is at its rollover value.
      assign carry[gi+1]  = carry[gi]  && (cur_dig == 4'd9);
      assign borrow[gi+1] = borrow[gi] && (cur_dig == 4'd0);

      assign inc_val[4*gi +: 4] = !carry[gi]         ? cur_dig :
                                  (cur_dig == 4'd9)  ? 4'd0    : cur_dig + 4'd1;
      assign dec_val[4*gi +: 4] = !borrow[gi]        ? cur_dig :
                                  (cur_dig == 4'd0)  ? 4'd9    : cur_dig - 4'd1;

      // Non-BCD preset digits are clamped so the count stays legal BCD.
      assign load_sat[4*gi +: 4] = (pre_dig > 4'd9) ? 4'd9 : pre_dig;
    end
  endgenerate

  assign all_nine = carry[DIGITS];
  assign all_zero = borrow[DIGITS];

  // Count next state: clear, then preset (which swallows a coincident tick),
  // then a tick in the freshly updated direction with wrap/saturate at limits.
  always_comb begin
    count_d = count_q;
    if (clear_req) begin
      count_d = '0;
    end else if (load_en) begin
      count_d = load_sat;
    end else if (tick) begin
      if (dir_d == DIR_UP) begin
        if (!all_nine) begin
          count_d = inc_val;
        end else if (wrap_en) begin
          count_d = '0;
        end
      end else begin
        if (!all_zero) begin
          count_d = dec_val;
        end else if (wrap_en) begin
          count_d = ALL9;
        end
      end
    end
  end

  // LED next state reflects the count and direction being registered now.
  logic [2:0] led_q, led_d;
  logic       at_limit;

  assign at_limit = !wrap_en &&
                    (((count_d == ALL9) && (dir_d == DIR_UP)) ||
                     ((count_d == '0)   && (dir_d == DIR_DOWN)));

  always_comb begin
    led_d = {at_limit, dir_d == DIR_UP, dir_d == DIR_DOWN};
  end

  // Count and LED registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      led_q   <= '0;
    end else begin
      count_q <= count_d;
      led_q   <= led_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display multiplexer
  // ---------------------------------------------------------------------------
  logic [SW-1:0]     scan_q, scan_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        show_dig;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h7F;
    endcase
    return p;
  endfunction

  assign show_dig = count_q[{digit_d, 2'b00} +: 4];

  // Scan/digit sequencing; an and seg are computed from the next scan
  // position so both registers change on the same edge as the scan counter.
  always_comb begin
    scan_d  = (scan_q == LAST_S) ? '0 : scan_q + SW'(1);
    digit_d = digit_q;
    if (scan_q == LAST_S) begin
      digit_d = (digit_q == LAST_D) ? '0 : digit_q + DW'(1);
    end
    an_d = ~(DIGITS'(1) << digit_d);
    if ((scan_d < BLANK_S) || (scan_d >= END_S)) begin
      an_d = '1;
    end
    // The segment pattern is latched once per slot so a count change
    // mid-slot never produces a torn digit.
    seg_d = seg_q;
    if (scan_d == BLANK_S) begin
      seg_d = seg_lut(show_dig);
    end
  end

  // Display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q  <= '0;
      digit_q <= '0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
    end else begin
      scan_q  <= scan_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign count = count_q;
  assign led   = led_q;
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_bcd_updown_stopwatch.sv
// Self-checking bench for bcd_updown_stopwatch: directed steps followed by a
// randomized phase, all compared against a decimal-arithmetic reference model.
module tb_bcd_updown_stopwatch;

  localparam int DIGITS   = 4;
  localparam int RATE_W   = 5;
  localparam int SCAN_DIV = 100;
  localparam int BLANK    = 10;
  localparam int MAXV     = 9999;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        btn;
  logic [RATE_W-1:0] rate;
  logic              wrap_en;
  logic              load_en;
  logic [15:0]       load_val;
  logic [15:0]       count;
  logic [2:0]        led;
  logic [6:0]        seg;
  logic [3:0]        an;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_updown_stopwatch #(
    .DIGITS(DIGITS), .RATE_W(RATE_W), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .rate(rate), .wrap_en(wrap_en),
    .load_en(load_en), .load_val(load_val), .count(count), .led(led),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: count as a plain decimal integer, direction 0/1/2 = stop/up/down
  // ---------------------------------------------------------------------------
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int load_decimal(input logic [15:0] lv);
    int s = 0;
    int d;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      s = s + d * pow10(i);
    end
    return s;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  int          m_count, m_dir, m_scan, m_digit;
  longint      m_presc;
  logic [2:0]  m_led;
  logic [6:0]  m_seg;
  logic [3:0]  m_an;
  logic [3:0]  bh0, bh1;
  logic [4:0]  rh0, rh1;

  int          nx_count, nx_dir, nx_scan, nx_digit;
  longint      nx_presc, period;
  logic        tick;
  logic [2:0]  nx_led;
  logic [6:0]  nx_seg;
  logic [3:0]  nx_an;

  // Next model state; buttons/rate take effect two edges after sampling.
  always_comb begin
    nx_dir = m_dir;
    if (bh1[3] || bh1[2]) nx_dir = 0;
    else if (bh1[1])      nx_dir = 1;
    else if (bh1[0])      nx_dir = 2;

    period = 64'd1 << rh1;
    tick   = 1'b0;
    if (bh1[3] || nx_dir == 0) nx_presc = 0;
    else if (m_presc >= period - 1) begin
      tick     = 1'b1;
      nx_presc = 0;
    end else nx_presc = m_presc + 1;

    nx_count = m_count;
    if (bh1[3]) nx_count = 0;
    else if (load_en) nx_count = load_decimal(load_val);
    else if (tick) begin
      if (nx_dir == 1) nx_count = (m_count == MAXV) ? (wrap_en ? 0 : MAXV) : m_count + 1;
      else             nx_count = (m_count == 0) ? (wrap_en ? MAXV : 0) : m_count - 1;
    end

    nx_led = {!wrap_en && ((nx_count == MAXV && nx_dir == 1) || (nx_count == 0 && nx_dir == 2)),
              nx_dir == 1, nx_dir == 2};

    nx_scan  = (m_scan + 1) % SCAN_DIV;
    nx_digit = (nx_scan == 0) ? (m_digit + 1) % DIGITS : m_digit;
    nx_an    = (nx_scan < BLANK || nx_scan >= SCAN_DIV - BLANK) ? 4'hF : ~(4'b0001 << nx_digit);
    nx_seg   = m_seg;
    if (nx_scan == BLANK) nx_seg = seg_tab[(m_count / pow10(nx_digit)) % 10];
  end

  always @(posedge clk) begin
    if (rst) begin
      m_count <= 0; m_dir <= 0; m_presc <= 0; m_scan <= 0; m_digit <= 0;
      m_led <= 3'b000; m_seg <= 7'h7F; m_an <= 4'hF;
      bh0 <= 4'h0; bh1 <= 4'h0; rh0 <= 5'd0; rh1 <= 5'd0;
    end else begin
      m_count <= nx_count; m_dir <= nx_dir; m_presc <= nx_presc;
      m_scan <= nx_scan; m_digit <= nx_digit;
      m_led <= nx_led; m_seg <= nx_seg; m_an <= nx_an;
      bh0 <= btn; bh1 <= bh0; rh0 <= rate; rh1 <= rh0;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check_all(input string tag);
    logic [15:0] exp_cnt;
    exp_cnt = to_bcd(m_count);
    n_checks++;
    assert (count === exp_cnt) else begin
      n_fail++; $error("FAIL %s count observed=%h expected=%h", tag, count, exp_cnt);
    end
    n_checks++;
    assert (led === m_led) else begin
      n_fail++; $error("FAIL %s led observed=%b expected=%b", tag, led, m_led);
    end
    n_checks++;
    assert (an === m_an) else begin
      n_fail++; $error("FAIL %s an observed=%b expected=%b", tag, an, m_an);
    end
    n_checks++;
    assert (seg === m_seg) else begin
      n_fail++; $error("FAIL %s seg observed=%h expected=%h", tag, seg, m_seg);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++; $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      @(negedge clk);
      check_all(tag);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load_en  = 1'b1;
    run(1, "load");
    load_en  = 1'b0;
    $display("load %h -> count %h", v, count);
  endtask

  task automatic wait_slot(input int d, input int s);
    for (int i = 0; i < 1000 && !(m_digit == d && m_scan == s); i++) run(1, "wait");
    chk("wait_slot_reached", {16'(m_digit), 16'(m_scan)}, {16'(d), 16'(s)});
  endtask

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; btn = 4'h0; rate = '0; wrap_en = 1'b0; load_en = 1'b0; load_val = '0;

    // 1: reset state, then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_led",   32'(led),   32'h0);
    chk("rst_an",    32'(an),    32'hF);
    chk("rst_seg",   32'(seg),   32'h7F);
    check_all("reset");
    rst = 1'b0;
    run(5, "idle");
    chk("idle_count", 32'(count), 32'h0);
    $display("reset/idle done count=%h led=%b", count, led);

    // 2: rate 0, up held -> 3-edge latency, BCD carry at 0009->0010
    do_load(16'h0007);
    btn = 4'b0010;
    run(2, "up_lat");
    chk("up_lat_count", 32'(count), 32'h0007);
    chk("up_lat_led",   32'(led),   32'b000);
    run(1, "up1");
    chk("up1_led",   32'(led),   32'b010);
    chk("up1_count", 32'(count), 32'h0008);
    run(1, "up2");
    chk("up2_count", 32'(count), 32'h0009);
    run(1, "up3");
    chk("up3_count", 32'(count), 32'h0010);
    btn = 4'h0;
    $display("up count reached %h", count);

    // 3: rate 3 -> ticks every 8 cycles, 0099 -> 0100
    btn = 4'b0100;
    run(4, "stop");
    btn = 4'h0; rate = 5'd3;
    do_load(16'h0099);
    run(3, "rate_sync");
    btn = 4'b0010;
    run(9, "r3_wait");
    chk("r3_before", 32'(count), 32'h0099);
    run(1, "r3_tick1");
    chk("r3_tick1", 32'(count), 32'h0100);
    btn = 4'h0;
    run(7, "r3_gap");
    chk("r3_gap", 32'(count), 32'h0100);
    run(1, "r3_tick2");
    chk("r3_tick2", 32'(count), 32'h0101);
    $display("rate3 ticks ok count=%h", count);

    // 4: saturate at 9999 going up, then wrap to 0000
    rate = 5'd0;
    run(3, "rate0_sync");
    wrap_en = 1'b0;
    do_load(16'h9999);
    run(3, "sat_hold");
    chk("sat_count", 32'(count), 32'h9999);
    chk("sat_led",   32'(led),   32'b110);
    wrap_en = 1'b1;
    run(1, "wrap_up");
    chk("wrap_count", 32'(count), 32'h0000);
    chk("wrap_led",   32'(led),   32'b010);
    $display("wrap up count=%h led=%b", count, led);

    // 5: down saturate at 0, up beats down, clear beats up
    wrap_en = 1'b0;
    btn = 4'b0001;
    do_load(16'h0000);
    run(4, "down_sat");
    chk("dsat_count", 32'(count), 32'h0000);
    chk("dsat_led",   32'(led),   32'b101);
    btn = 4'b0011;
    run(3, "up_wins");
    chk("upwin_led", 32'(led), 32'b010);
    btn = 4'b1010;
    run(3, "clear");
    chk("clear_count", 32'(count), 32'h0000);
    chk("clear_led",   32'(led),   32'b000);
    btn = 4'h0;
    run(3, "clear_rel");
    $display("priority steps done count=%h led=%b", count, led);

    // 6: display scan of 1234 while stopped
    do_load(16'h1234);
    wait_slot(0, 0);
    for (int s = 0; s < SCAN_DIV; s++) begin
      chk("slot0_an", 32'(an), (s < BLANK || s >= SCAN_DIV - BLANK) ? 32'hF : 32'hE);
      if (s >= BLANK) chk("slot0_seg", 32'(seg), 32'h19);
      run(1, "slot0");
    end
    wait_slot(1, 50);
    chk("slot1_an",  32'(an),  32'hD);
    chk("slot1_seg", 32'(seg), 32'h30);
    wait_slot(3, 50);
    chk("slot3_an",  32'(an),  32'h7);
    chk("slot3_seg", 32'(seg), 32'h79);
    wait_slot(0, 50);
    chk("slot0b_an",  32'(an),  32'hE);
    chk("slot0b_seg", 32'(seg), 32'h19);
    $display("display scan done an=%b seg=%h", an, seg);

    // Randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3)       btn = 4'b1000;
      else if (r < 12) btn = 4'b0001 << $urandom_range(0, 2);
      else if (r < 15) btn = 4'($urandom_range(0, 15));
      else if (r < 35) btn = 4'h0;
      if ($urandom_range(0, 49) == 0) rate = 5'($urandom_range(0, 2));
      if ($urandom_range(0, 39) == 0) wrap_en = ~wrap_en;
      load_en  = ($urandom_range(0, 29) == 0);
      load_val = 16'($urandom);
      rst      = ($urandom_range(0, 499) == 0);
      run(1, "rand");
      if (load_en) $display("rand load %h -> count %h led %b", load_val, count, led);
    end
    rst = 1'b0; load_en = 1'b0; btn = 4'h0;
    run(4, "tail");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
